// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, redirect, stall and sticky HALT.
// Optional retired-fetch counter enabled by FETCH_INST_COUNT_EN.
module fetch_unit #(
    parameter int unsigned PC_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0] NOP_INST = 16'h0020,
    parameter logic [15:0] HALT_INST = 16'hFFFF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_addr_i,
    input  logic            branch_i,
    input  logic [7:0]      displacement_i,
    input  logic [15:0]     mem_data_i,
    output logic [PC_W-1:0] mem_addr_o,
    output logic [PC_W-1:0] pc_o,
    output logic [15:0]     inst_o,
    output logic            valid_o,
`ifdef FETCH_INST_COUNT_EN
    output logic [15:0]     inst_count_o,
`endif
    output logic            halted_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] disp_ext;
    logic            halt_word;
    logic            fetch_ok;

    assign halt_word = (mem_data_i == HALT_INST);
    assign fetch_ok  = (state_q == S_RUN) && !halt_word;
    assign disp_ext  = PC_W'($signed(displacement_i));

    // Redirects outrank stall and the HALT word so they are never dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (jump_i) begin
                    pc_d = jump_addr_i;
                end else if (branch_i) begin
                    pc_d = pc_q + disp_ext;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (halt_word) begin
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_INST_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_ok && !stall_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inst_count_o = cnt_q;
`endif

    assign pc_o       = pc_q;
    assign mem_addr_o = pc_q;
    assign inst_o     = fetch_ok ? mem_data_i : NOP_INST;
    assign valid_o    = fetch_ok;
    assign halted_o   = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a behavioural fetch model.
// Builds with or without FETCH_INST_COUNT_EN.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump;
    logic [7:0]  jaddr;
    logic        branch;
    logic [7:0]  disp;
    logic [15:0] mdata;
    logic [7:0]  maddr;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic        valid;
    logic        halted;
`ifdef FETCH_INST_COUNT_EN
    logic [15:0] icount;
`endif

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 run, 2 halt
    int          m_state;
    logic [7:0]  m_pc;
    int          m_cnt;

    fetch_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .jump_i         (jump),
        .jump_addr_i    (jaddr),
        .branch_i       (branch),
        .displacement_i (disp),
        .mem_data_i     (mdata),
        .mem_addr_o     (maddr),
        .pc_o           (pc),
        .inst_o         (inst),
        .valid_o        (valid),
`ifdef FETCH_INST_COUNT_EN
        .inst_count_o   (icount),
`endif
        .halted_o       (halted)
    );

    assign mdata = mem[maddr];

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_inst();
        if (m_state == 1 && mem[m_pc] != 16'hFFFF) return mem[m_pc];
        return 16'h0020;
    endfunction

    function automatic logic exp_valid();
        return (m_state == 1 && mem[m_pc] != 16'hFFFF);
    endfunction

    task automatic fill_mem();
        for (int n = 0; n < 256; n++) mem[n] = 16'(n + 16'h1000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        stall = 0; jump = 0; branch = 0; jaddr = 0; disp = 0;
        #2;
        m_state = 0; m_pc = 0; m_cnt = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic step(input bit st, input bit jp, input logic [7:0] ja,
                        input bit br, input logic [7:0] d);
        int npc;
        int nst;
        stall = st; jump = jp; jaddr = ja; branch = br; disp = d;
        npc = m_pc;
        nst = m_state;
        if (m_state == 0) begin
            nst = 1;
        end else if (m_state == 1) begin
            if (mem[m_pc] != 16'hFFFF && !st && m_cnt < 65535)
                m_cnt++;
            if (jp) npc = ja;
            else if (br) npc = (int'(m_pc) + int'($signed(d))) & 255;
            else if (st) npc = m_pc;
            else if (mem[m_pc] == 16'hFFFF) nst = 2;
            else npc = (int'(m_pc) + 1) % 256;
        end
        @(posedge clk);
        m_pc = 8'(npc);
        m_state = nst;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        stall = 0; jump = 0; branch = 0; jaddr = 0; disp = 0;
        fill_mem();
        #1;
        checks++;
        if (pc !== 8'h00 || halted !== 1'b0 || valid !== 1'b0
            || inst !== 16'h0020) begin
            errors++;
            $display("FAIL reset pc=%h inst=%h v=%b h=%b exp 00 0020 0 0",
                     pc, inst, valid, halted);
        end
    endtask

    task automatic test_run();
        do_reset();
        checks++;
        if (inst !== 16'h0020 || valid !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL idle inst=%h v=%b pc=%h exp 0020 0 00",
                     inst, valid, pc);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (pc !== 8'(i) || inst !== 16'(16'h1000 + i) || valid !== 1) begin
                errors++;
                $display("FAIL run%0d pc=%h inst=%h v=%b exp %h %h 1",
                         i, pc, inst, valid, 8'(i), 16'(16'h1000 + i));
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        step(0, 0, 0, 0, 0);
`ifdef FETCH_INST_COUNT_EN
        checks++;
        if (icount !== 16'd3) begin
            errors++;
            $display("FAIL count3 got %0d exp 3", icount);
        end
`endif
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        held = inst;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0);
            checks++;
            if (pc !== 8'h05 || inst !== held) begin
                errors++;
                $display("FAIL stall%0d pc=%h inst=%h exp 05 %h",
                         i, pc, inst, held);
            end
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (pc !== 8'h06) begin
            errors++;
            $display("FAIL unstall pc=%h exp 06", pc);
        end
    endtask

    task automatic test_jump_branch();
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 8'h40, 0, 0);
        checks++;
        if (pc !== 8'h40) begin
            errors++;
            $display("FAIL jump pc=%h exp 40", pc);
        end
        step(0, 0, 0, 1, 8'hFC);
        checks++;
        if (pc !== 8'h3C || inst !== 16'h103C) begin
            errors++;
            $display("FAIL branch_back pc=%h inst=%h exp 3c 103c", pc, inst);
        end
        step(0, 1, 8'h22, 1, 8'h05);
        checks++;
        if (pc !== 8'h22) begin
            errors++;
            $display("FAIL jump_wins pc=%h exp 22", pc);
        end
        step(0, 1, 8'h10, 0, 0);
        step(0, 0, 0, 1, 8'hFE);
        checks++;
        if (pc !== 8'h0E) begin
            errors++;
            $display("FAIL branch_neg pc=%h exp 0e", pc);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 8'hFE, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (pc !== 8'h00 || inst !== 16'h1000) begin
            errors++;
            $display("FAIL wrap_seq pc=%h inst=%h exp 00 1000", pc, inst);
        end
        step(0, 1, 8'hFF, 0, 0);
        step(0, 0, 0, 1, 8'h02);
        checks++;
        if (pc !== 8'h01) begin
            errors++;
            $display("FAIL wrap_branch pc=%h exp 01", pc);
        end
    endtask

    task automatic test_halt();
        mem[7] = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        checks++;
        if (pc !== 8'h07 || inst !== 16'h0020 || valid !== 0 || halted !== 0) begin
            errors++;
            $display("FAIL halt_word pc=%h inst=%h v=%b h=%b exp 07 0020 0 0",
                     pc, inst, valid, halted);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (halted !== 1 || pc !== 8'h07) begin
            errors++;
            $display("FAIL halted h=%b pc=%h exp 1 07", halted, pc);
        end
        step(0, 1, 8'h33, 0, 0);
        step(1, 1, 8'h44, 1, 8'h05);
        step(0, 0, 0, 1, 8'h10);
        checks++;
        if (halted !== 1 || pc !== 8'h07 || valid !== 0) begin
            errors++;
            $display("FAIL halt_sticky h=%b pc=%h v=%b exp 1 07 0",
                     halted, pc, valid);
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if (halted !== 0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL halt_reset h=%b pc=%h exp 0 00", halted, pc);
        end
        m_state = 0; m_pc = 0; m_cnt = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_redirect_halt();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        checks++;
        if (halted !== 0 || pc !== 8'h55 || valid !== 1) begin
            errors++;
            $display("FAIL jump_beats_halt h=%b pc=%h v=%b exp 0 55 1",
                     halted, pc, valid);
        end
        step(0, 1, 8'h07, 0, 0);
        step(0, 0, 0, 1, 8'h03);
        checks++;
        if (halted !== 0 || pc !== 8'h0A) begin
            errors++;
            $display("FAIL branch_beats_halt h=%b pc=%h exp 0 0a", halted, pc);
        end
        mem[7] = 16'h1007;
    endtask

    task automatic test_random();
        for (int n = 0; n < 256; n++)
            mem[n] = ($urandom_range(0, 11) == 0) ? 16'hFFFF : 16'($urandom);
        do_reset();
        for (int c = 0; c < 600; c++) begin
            checks++;
            if (pc !== m_pc || inst !== exp_inst() || valid !== exp_valid()
                || halted !== (m_state == 2)) begin
                errors++;
                $display("FAIL rand%0d pc=%h/%h inst=%h/%h v=%b/%b h=%b/%b",
                         c, pc, m_pc, inst, exp_inst(), valid, exp_valid(),
                         halted, (m_state == 2));
            end
`ifdef FETCH_INST_COUNT_EN
            checks++;
            if (icount !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_count%0d got %0d exp %0d", c, icount, m_cnt);
            end
`endif
            if (m_state == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0, 8'($urandom),
                     $urandom_range(0, 7) == 0, 8'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_jump_branch();
        test_wrap();
        test_halt();
        test_redirect_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
